// File: rtl/hex_ascii_tx_sequencer_pkg.sv
// Shared types and constants for the hex-to-ASCII character sequencer.
package hex_ascii_tx_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHex,
        StCr,
        StLf
    } state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/hex_ascii_tx_sequencer_hex_to_ascii.sv
// Nibble to upper-case ASCII hex digit converter (purely combinational).
module hex_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/hex_ascii_tx_sequencer.sv
// Serialises a raw word as an ASCII hex string, MS nibble first, with optional CR/LF.
module hex_ascii_tx_sequencer
    import hex_ascii_tx_sequencer_pkg::*;
#(
    parameter int unsigned NUM_BYTES   = 2,
    parameter bit          APPEND_CRLF = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_BYTES*8-1:0] in_data,
    output logic                   char_valid,
    input  logic                   char_ready,
    output logic [7:0]             char_data,
    output logic                   busy
);

    localparam int unsigned NumNibs = NUM_BYTES * 2;
    localparam int unsigned IdxW    = (NumNibs > 1) ? $clog2(NumNibs) : 1;

    state_e                 state_q, state_d;
    logic [NUM_BYTES*8-1:0] word_q, word_d;
    logic [IdxW-1:0]        nib_idx_q, nib_idx_d;
    logic [3:0]             nibble;
    logic [7:0]             hex_char;

    // Digit selection is from registers only, so no path from char_ready reaches the outputs.
    assign nibble = word_q[{nib_idx_q, 2'b00} +: 4];

    hex_to_ascii u_hex_to_ascii (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        nib_idx_d  = nib_idx_q;
        in_ready   = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        busy       = (state_q != StIdle);

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d    = in_data;
                    nib_idx_d = IdxW'(NumNibs - 1);
                    state_d   = StHex;
                end
            end
            StHex: begin
                char_valid = 1'b1;
                char_data  = hex_char;
                if (char_ready) begin
                    if (nib_idx_q == '0) begin
                        state_d = APPEND_CRLF ? StCr : StIdle;
                    end else begin
                        nib_idx_d = nib_idx_q - IdxW'(1);
                    end
                end
            end
            StCr: begin
                char_valid = 1'b1;
                char_data  = ASCII_CR;
                if (char_ready) begin
                    state_d = StLf;
                end
            end
            StLf: begin
                char_valid = 1'b1;
                char_data  = ASCII_LF;
                if (char_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            word_q    <= '0;
            nib_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            nib_idx_q <= nib_idx_d;
        end
    end

endmodule
